fetch_out_queue: RTL and testbench

//  Circular FIFO between the instruction fetch/decode stage and dispatch.

---
 rtl/fetch_out_queue_pkg.sv | 48 ++++
 rtl/fetch_out_queue_ram.sv | 25 ++
 rtl/fetch_out_queue.sv | 142 ++++++++++++++
 tb/tb_fetch_out_queue.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_out_queue_pkg.sv
// Shared types for the fetch-out queue: entry layout, field offsets, opcode encodings.
package fetch_out_queue_pkg;

  localparam int FOQ_DEPTH   = 8;
  localparam int FOQ_PTR_W   = 3;
  localparam int FOQ_ENTRY_W = 89;

  localparam int FOQ_OFF_OP      = 0;
  localparam int FOQ_OFF_BRANCH  = 5;
  localparam int FOQ_OFF_LS      = 6;
  localparam int FOQ_OFF_USE_IMM = 7;
  localparam int FOQ_OFF_RD      = 8;
  localparam int FOQ_OFF_RS1     = 13;
  localparam int FOQ_OFF_RS2     = 18;
  localparam int FOQ_OFF_IMM     = 23;
  localparam int FOQ_OFF_JALR    = 55;
  localparam int FOQ_OFF_PC      = 56;
  localparam int FOQ_OFF_PRED    = 88;

  typedef enum logic [4:0] {
    OP_NOP  = 5'd0,
    OP_ALU  = 5'd1,
    OP_ALUI = 5'd2,
    OP_LOAD = 5'd3,
    OP_STOR = 5'd4,
    OP_BRCH = 5'd5,
    OP_JAL  = 5'd6,
    OP_JALR = 5'd7,
    OP_LUI  = 5'd8,
    OP_AUIP = 5'd9
  } foq_op_e;

  // Member order puts op at bit 0 and pred at the MSB, matching the offsets above.
  typedef struct packed {
    logic        pred;
    logic [31:0] pc;
    logic        jalr;
    logic [31:0] imm;
    logic [4:0]  rs2;
    logic [4:0]  rs1;
    logic [4:0]  rd;
    logic        use_imm;
    logic        ls;
    logic        branch;
    logic [4:0]  op;
  } foq_entry_t;

endpackage

// File: rtl/fetch_out_queue_ram.sv
// Entry storage for the fetch-out queue: one synchronous write port, asynchronous read.
module foq_ram
  import fetch_out_queue_pkg::*;
#(
  parameter int DEPTH = FOQ_DEPTH,
  parameter int PTR_W = FOQ_PTR_W,
  parameter int W     = FOQ_ENTRY_W
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [PTR_W-1:0] waddr_i,
  input  logic [W-1:0]     wdata_i,
  input  logic [PTR_W-1:0] raddr_i,
  output logic [W-1:0]     rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_out_queue.sv
// Fetch-to-dispatch circular FIFO with flush; optional empty-queue bypass when
// FOQ_BYPASS_EN is defined.
module fetch_out_queue
  import fetch_out_queue_pkg::*;
#(
  parameter int DEPTH = FOQ_DEPTH,
  parameter int PTR_W = FOQ_PTR_W
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             flush,
  input  logic             enq_valid,
  input  logic [31:0]      enq_pc,
  input  logic             enq_pred,
  input  logic [4:0]       enq_op,
  input  logic             enq_branch,
  input  logic             enq_ls,
  input  logic             enq_use_imm,
  input  logic             enq_jalr,
  input  logic [4:0]       enq_rd,
  input  logic [4:0]       enq_rs1,
  input  logic [4:0]       enq_rs2,
  input  logic [31:0]      enq_imm,
  output logic             foq_full,
  output logic             deq_valid,
  input  logic             deq_ready,
  output logic [31:0]      deq_pc,
  output logic             deq_pred,
  output logic [4:0]       deq_op,
  output logic             deq_branch,
  output logic             deq_ls,
  output logic             deq_use_imm,
  output logic             deq_jalr,
  output logic [4:0]       deq_rd,
  output logic [4:0]       deq_rs1,
  output logic [4:0]       deq_rs2,
  output logic [31:0]      deq_imm,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;

  foq_entry_t wr_entry, rd_entry, out_entry;
  logic       stored_valid, full, bypass, bypass_take, enq_fire, deq_fire;

  always_comb begin
    wr_entry         = '0;
    wr_entry.pred    = enq_pred;
    wr_entry.pc      = enq_pc;
    wr_entry.jalr    = enq_jalr;
    wr_entry.imm     = enq_imm;
    wr_entry.rs2     = enq_rs2;
    wr_entry.rs1     = enq_rs1;
    wr_entry.rd      = enq_rd;
    wr_entry.use_imm = enq_use_imm;
    wr_entry.ls      = enq_ls;
    wr_entry.branch  = enq_branch;
    wr_entry.op      = enq_op;
  end

  assign stored_valid = (count_q != '0);
  assign full         = (count_q == FULL_CNT);

`ifdef FOQ_BYPASS_EN
  assign bypass = !stored_valid && enq_valid && !flush;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed entry consumed in the same cycle never touches storage.
  assign bypass_take = bypass && rdy_in && deq_ready;
  assign enq_fire    = rdy_in && enq_valid && !full && !flush && !bypass_take;
  assign deq_fire    = rdy_in && stored_valid && deq_ready && !flush;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq_fire) tail_d = tail_q + 1'b1;
      if (deq_fire) head_d = head_q + 1'b1;
      count_d = count_q + (PTR_W+1)'(enq_fire) - (PTR_W+1)'(deq_fire);
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  foq_ram #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .W     (FOQ_ENTRY_W)
  ) u_ram (
    .clk_i   (clk_in),
    .we_i    (enq_fire),
    .waddr_i (tail_q),
    .wdata_i (wr_entry),
    .raddr_i (head_q),
    .rdata_o (rd_entry)
  );

  // Storage is not reset, so the head is masked to zero whenever the queue is empty.
  always_comb begin
    out_entry = '0;
    if (bypass)            out_entry = wr_entry;
    else if (stored_valid) out_entry = rd_entry;
  end

  assign foq_full    = full;
  assign deq_valid   = stored_valid || bypass;
  assign count       = count_q;
  assign deq_pc      = out_entry.pc;
  assign deq_pred    = out_entry.pred;
  assign deq_op      = out_entry.op;
  assign deq_branch  = out_entry.branch;
  assign deq_ls      = out_entry.ls;
  assign deq_use_imm = out_entry.use_imm;
  assign deq_jalr    = out_entry.jalr;
  assign deq_rd      = out_entry.rd;
  assign deq_rs1     = out_entry.rs1;
  assign deq_rs2     = out_entry.rs2;
  assign deq_imm     = out_entry.imm;

endmodule

// File: tb/tb_fetch_out_queue.sv
// Bench for fetch_out_queue: queue-based reference model checked every cycle plus directed literal checks.
module tb_fetch_out_queue;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, flush, enq_valid, deq_ready;
  logic [31:0] enq_pc, enq_imm;
  logic        enq_pred, enq_branch, enq_ls, enq_use_imm, enq_jalr;
  logic [4:0]  enq_op, enq_rd, enq_rs1, enq_rs2;
  logic        foq_full, deq_valid;
  logic [31:0] deq_pc, deq_imm;
  logic        deq_pred, deq_branch, deq_ls, deq_use_imm, deq_jalr;
  logic [4:0]  deq_op, deq_rd, deq_rs1, deq_rs2;
  logic [3:0]  count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] pc;
    logic [56:0] rest;
  } ent_t;

  ent_t mq[$];

  always #5 clk_in = ~clk_in;

  fetch_out_queue dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
    .enq_valid(enq_valid), .enq_pc(enq_pc), .enq_pred(enq_pred), .enq_op(enq_op),
    .enq_branch(enq_branch), .enq_ls(enq_ls), .enq_use_imm(enq_use_imm),
    .enq_jalr(enq_jalr), .enq_rd(enq_rd), .enq_rs1(enq_rs1), .enq_rs2(enq_rs2),
    .enq_imm(enq_imm), .foq_full(foq_full), .deq_valid(deq_valid),
    .deq_ready(deq_ready), .deq_pc(deq_pc), .deq_pred(deq_pred), .deq_op(deq_op),
    .deq_branch(deq_branch), .deq_ls(deq_ls), .deq_use_imm(deq_use_imm),
    .deq_jalr(deq_jalr), .deq_rd(deq_rd), .deq_rs1(deq_rs1), .deq_rs2(deq_rs2),
    .deq_imm(deq_imm), .count(count)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [56:0] in_rest();
    return {enq_pred, enq_op, enq_branch, enq_ls, enq_use_imm, enq_jalr,
            enq_rd, enq_rs1, enq_rs2, enq_imm};
  endfunction

  function automatic logic [56:0] out_rest();
    return {deq_pred, deq_op, deq_branch, deq_ls, deq_use_imm, deq_jalr,
            deq_rd, deq_rs1, deq_rs2, deq_imm};
  endfunction

  function automatic logic model_bypass();
`ifdef FOQ_BYPASS_EN
    return (mq.size() == 0) && enq_valid && !flush;
`else
    return 1'b0;
`endif
  endfunction

  // Reference model: plain queue semantics of the FIFO rules.
  always @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      mq.delete();
    end else if (flush) begin
      mq.delete();
    end else if (rdy_in) begin
      automatic logic byp    = model_bypass();
      automatic logic enq_ok = enq_valid && (mq.size() < 8);
      automatic logic deq_ok = deq_ready && ((mq.size() > 0) || byp);
      automatic ent_t e;
      e.pc   = enq_pc;
      e.rest = in_rest();
      if (!(byp && deq_ok)) begin
        if (deq_ok) void'(mq.pop_front());
        if (enq_ok) mq.push_back(e);
      end
    end
  end

  always @(negedge clk_in) begin
    automatic logic byp = model_bypass();
    automatic logic ev  = (mq.size() != 0) || byp;
    chk("m_count", 64'(count), 64'(mq.size()));
    chk("m_full",  64'(foq_full), 64'(mq.size() == 8));
    chk("m_valid", 64'(deq_valid), 64'(ev));
    if (byp) begin
      chk("m_pc",   64'(deq_pc), 64'(enq_pc));
      chk("m_rest", 64'(out_rest()), 64'(in_rest()));
    end else if (mq.size() != 0) begin
      chk("m_pc",   64'(deq_pc), 64'(mq[0].pc));
      chk("m_rest", 64'(out_rest()), 64'(mq[0].rest));
    end
  end

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_enq(input logic v, input logic [31:0] pc);
    enq_valid   = v;
    enq_pc      = pc;
    enq_pred    = pc[2];
    enq_op      = pc[6:2];
    enq_branch  = pc[3];
    enq_ls      = pc[4];
    enq_use_imm = pc[5];
    enq_jalr    = pc[2] ^ pc[3];
    enq_rd      = pc[6:2] + 5'd1;
    enq_rs1     = pc[8:4];
    enq_rs2     = ~pc[6:2];
    enq_imm     = ~pc ^ 32'h5a5a_0000;
  endtask

  initial begin
    rst_in = 1'b0; rdy_in = 1'b1; flush = 1'b0; deq_ready = 1'b0;
    set_enq(1'b0, 32'h0);
    cyc(); cyc();
    rst_in = 1'b1;
    cyc();
    chk("reset_count", 64'(count), 64'd0);

    // Reset mid-stream with 3 entries buffered
    for (int i = 0; i < 3; i++) begin set_enq(1'b1, 32'h80 + 32'(i) * 4); cyc(); end
    set_enq(1'b0, 32'h0);
    chk("pre_rst_count", 64'(count), 64'd3);
    #2 rst_in = 1'b0;
    #1;
    chk("rst_valid", 64'(deq_valid), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_full",  64'(foq_full), 64'd0);
    chk("rst_pc",    64'(deq_pc), 64'd0);
    #3 rst_in = 1'b1;
    cyc();

    // Fill to full, drop 9th, drain in order
    for (int i = 0; i < 8; i++) begin set_enq(1'b1, 32'(i) * 4); cyc(); end
    chk("fill_count", 64'(count), 64'd8);
    chk("fill_full",  64'(foq_full), 64'd1);
    set_enq(1'b1, 32'h20);
    cyc();
    chk("drop_count", 64'(count), 64'd8);
    set_enq(1'b0, 32'h0);
    deq_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_in);
      chk("drain_pc", 64'(deq_pc), 64'(32'(i) * 4));
      cyc();
    end
    chk("drain_valid", 64'(deq_valid), 64'd0);
    chk("drain_count", 64'(count), 64'd0);
    deq_ready = 1'b0;

    // Steady enq+deq at count=3 across pointer wrap
    for (int i = 0; i < 3; i++) begin set_enq(1'b1, 32'h100 + 32'(i) * 4); cyc(); end
    deq_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin set_enq(1'b1, 32'h10c + 32'(i) * 4); cyc(); end
    set_enq(1'b0, 32'h0);
    deq_ready = 1'b0;
    chk("steady_count", 64'(count), 64'd3);
    chk("steady_head",  64'(deq_pc), 64'h150);

    // Flush at count=5 with concurrent enq and deq
    set_enq(1'b1, 32'h200); cyc();
    set_enq(1'b1, 32'h204); cyc();
    chk("pre_flush_count", 64'(count), 64'd5);
    flush = 1'b1; set_enq(1'b1, 32'h300); deq_ready = 1'b1;
    cyc();
    flush = 1'b0; set_enq(1'b0, 32'h0); deq_ready = 1'b0;
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_valid", 64'(deq_valid), 64'd0);

    // rdy_in low freezes; flush still acts
    set_enq(1'b1, 32'h400); cyc();
    set_enq(1'b1, 32'h404); cyc();
    rdy_in = 1'b0; set_enq(1'b1, 32'h408); deq_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("frz_count", 64'(count), 64'd2);
      chk("frz_pc",    64'(deq_pc), 64'h400);
    end
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("frz_flush_count", 64'(count), 64'd0);
    rdy_in = 1'b1; set_enq(1'b0, 32'h0); deq_ready = 1'b0;
    cyc();

    // Empty-queue enqueue with deq_ready: bypass vs. one-cycle latency
    set_enq(1'b1, 32'h40); deq_ready = 1'b1;
    #1;
`ifdef FOQ_BYPASS_EN
    chk("byp_valid", 64'(deq_valid), 64'd1);
    chk("byp_pc",    64'(deq_pc), 64'h40);
`else
    chk("lat_valid", 64'(deq_valid), 64'd0);
`endif
    cyc();
    set_enq(1'b0, 32'h0); deq_ready = 1'b0;
`ifdef FOQ_BYPASS_EN
    chk("byp_count", 64'(count), 64'd0);
`else
    chk("lat_count", 64'(count), 64'd1);
    chk("lat_valid2", 64'(deq_valid), 64'd1);
    chk("lat_pc",    64'(deq_pc), 64'h40);
`endif
    deq_ready = 1'b1;
    cyc();
    deq_ready = 1'b0;
    chk("end_count", 64'(count), 64'd0);
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
